// File: rtl/coord_stack.sv
// coord_stack: LIFO of (x,y) coordinate pairs with a registered pop port,
// a combinational top-of-stack view and one-cycle overflow/underflow pulses.
module coord_stack #(
  parameter  int XW    = 4,
  parameter  int YW    = 4,
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [XW-1:0] x_in,
  input  logic [YW-1:0] y_in,
  output logic [XW-1:0] x_out,
  output logic [YW-1:0] y_out,
  output logic          out_valid,
  output logic [XW-1:0] top_x,
  output logic [YW-1:0] top_y,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = XW + YW;

  typedef enum logic [2:0] {
    CMD_IDLE,
    CMD_CLEAR,
    CMD_SWAP,   // push and pop together
    CMD_PUSH,
    CMD_POP
  } cmd_e;

  logic [EW-1:0] mem [DEPTH];

  cmd_e          cmd;
  logic [AW-1:0] top_idx;
  logic [EW-1:0] top_entry;

  logic [CW-1:0] count_nx;
  logic [XW-1:0] x_out_nx;
  logic [YW-1:0] y_out_nx;
  logic          out_valid_nx;
  logic          overflow_nx;
  logic          underflow_nx;
  logic          wr_en;
  logic [AW-1:0] wr_idx;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign top_idx = AW'(count - CW'(1));

  // Top-of-stack view; the slot is only meaningful while non-empty.
  always_comb begin
    top_entry = mem[top_idx];
    top_x     = empty ? '0 : top_entry[EW-1:YW];
    top_y     = empty ? '0 : top_entry[YW-1:0];
  end

  // Command priority: clear, then push+pop, then push, then pop.
  always_comb begin
    if (clear)            cmd = CMD_CLEAR;
    else if (push && pop) cmd = CMD_SWAP;
    else if (push)        cmd = CMD_PUSH;
    else if (pop)         cmd = CMD_POP;
    else                  cmd = CMD_IDLE;
  end

  // Next-state decode for count, pop port, flags and the memory write.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    count_nx     = count;
    x_out_nx     = x_out;
    y_out_nx     = y_out;
    out_valid_nx = 1'b0;
    overflow_nx  = 1'b0;
    underflow_nx = 1'b0;
    wr_en        = 1'b0;
    wr_idx       = top_idx;
    unique case (cmd)
      CMD_CLEAR: count_nx = '0;
      CMD_SWAP: begin
        out_valid_nx = 1'b1;
        if (empty) begin
          // Nothing stored: the pushed pair passes straight through.
          x_out_nx = x_in;
          y_out_nx = y_in;
        end else begin
          // Old top leaves, new pair replaces it in the same slot.
          x_out_nx = top_entry[EW-1:YW];
          y_out_nx = top_entry[YW-1:0];
          wr_en    = 1'b1;
          wr_idx   = top_idx;
        end
      end
      CMD_PUSH: begin
        if (full) begin
          overflow_nx = 1'b1;
        end else begin
          wr_en    = 1'b1;
          wr_idx   = AW'(count);
          count_nx = count + CW'(1);
        end
      end
      CMD_POP: begin
        if (empty) begin
          underflow_nx = 1'b1;
        end else begin
          x_out_nx     = top_entry[EW-1:YW];
          y_out_nx     = top_entry[YW-1:0];
          out_valid_nx = 1'b1;
          count_nx     = count - CW'(1);
        end
      end
      default: ;
    endcase
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      count     <= '0;
      x_out     <= '0;
      y_out     <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_nx;
      x_out     <= x_out_nx;
      y_out     <= y_out_nx;
      out_valid <= out_valid_nx;
      overflow  <= overflow_nx;
      underflow <= underflow_nx;
    end
  end

  // Entry storage; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    // NOTE: the memory has no reset; stale slots are unreachable once count is 0.
    if (wr_en && !rst) mem[wr_idx] <= {x_in, y_in};
  end

endmodule

// File: tb/tb_coord_stack.sv
// tb_coord_stack: table-driven check of coord_stack (XW=YW=4, DEPTH=4) with a
// scoreboard queue for popped coordinates and hand-written reset sequences.
module tb_coord_stack;

  localparam int XW = 4;
  localparam int YW = 4;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          clear, push, pop;
  logic [XW-1:0] x_in, x_out, top_x;
  logic [YW-1:0] y_in, y_out, top_y;
  logic          out_valid, empty, full, overflow, underflow;
  logic [CW-1:0] count;

  coord_stack #(.XW(XW), .YW(YW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clear(clear), .push(push), .pop(pop),
    .x_in(x_in), .y_in(y_in), .x_out(x_out), .y_out(y_out),
    .out_valid(out_valid), .top_x(top_x), .top_y(top_y), .count(count),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr, psh, pp;
    logic [3:0] x, y;
    int         ecnt;
    logic [3:0] etx, ety;
    logic       eovf, eudf, eov;
    logic [3:0] eox, eoy;
  } vec_t;

  typedef struct {
    logic [3:0] x, y;
  } pt_t;

  vec_t vecs[$];
  pt_t  sb[$];
  pt_t  last_out;
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t v(logic clr, logic psh, logic pp, logic [3:0] x,
                             logic [3:0] y, int ecnt, logic [3:0] etx,
                             logic [3:0] ety, logic eovf, logic eudf,
                             logic eov, logic [3:0] eox, logic [3:0] eoy);
    vec_t t;
    t.clr = clr; t.psh = psh; t.pp = pp; t.x = x; t.y = y;
    t.ecnt = ecnt; t.etx = etx; t.ety = ety;
    t.eovf = eovf; t.eudf = eudf; t.eov = eov; t.eox = eox; t.eoy = eoy;
    return t;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic clr, logic psh, logic pp, logic [3:0] x, logic [3:0] y);
    clear = clr; push = psh; pop = pp; x_in = x; y_in = y;
  endtask

  // Drive one vector, clock it, then compare state, flags and the pop port.
  task automatic apply(vec_t t, string tag);
    pt_t p;
    drive(t.clr, t.psh, t.pp, t.x, t.y);
    if (t.eov) begin
      p.x = t.eox; p.y = t.eoy;
      sb.push_back(p);
    end
    @(posedge clk); #1;
    check({tag, ".count"}, 32'(count), 32'(t.ecnt));
    check({tag, ".top"}, {top_x, top_y}, {t.etx, t.ety});
    check({tag, ".empty"}, empty, t.ecnt == 0);
    check({tag, ".full"}, full, t.ecnt == DEPTH);
    check({tag, ".overflow"}, overflow, t.eovf);
    check({tag, ".underflow"}, underflow, t.eudf);
    check({tag, ".out_valid"}, out_valid, t.eov);
    if (out_valid) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL %s.unexpected_pop: got %0h%0h expected none", tag, x_out, y_out);
      end else begin
        p = sb.pop_front();
        check({tag, ".pop_xy"}, {x_out, y_out}, {p.x, p.y});
        last_out = p;
      end
    end else begin
      if (t.eov) void'(sb.pop_front());
      check({tag, ".hold_xy"}, {x_out, y_out}, {last_out.x, last_out.y});
    end
  endtask

  initial begin
    //          clr psh pp  x  y   cnt tx ty ovf udf ov ox oy
    vecs.push_back(v(0, 1, 0, 1, 2, 1, 1, 2, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 3, 4, 2, 3, 4, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 5, 6, 3, 5, 6, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 2, 3, 4, 0, 0, 1, 5, 6));
    vecs.push_back(v(0, 0, 1, 0, 0, 1, 1, 2, 0, 0, 1, 3, 4));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); // underflow
    vecs.push_back(v(0, 1, 1, 2, 3, 0, 0, 0, 0, 0, 1, 2, 3)); // forward
    vecs.push_back(v(0, 1, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 2, 2, 2, 2, 2, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 3, 3, 3, 3, 3, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 4, 4, 4, 4, 4, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 9, 9, 4, 4, 4, 1, 0, 0, 0, 0)); // overflow
    vecs.push_back(v(0, 0, 0, 0, 0, 4, 4, 4, 0, 0, 0, 0, 0)); // pulse ends
    vecs.push_back(v(0, 1, 1, 8, 8, 4, 8, 8, 0, 0, 1, 4, 4)); // swap at full
    vecs.push_back(v(0, 0, 1, 0, 0, 3, 3, 3, 0, 0, 1, 8, 8));
    vecs.push_back(v(0, 0, 1, 0, 0, 2, 2, 2, 0, 0, 1, 3, 3));
    vecs.push_back(v(0, 1, 0, 7, 7, 3, 7, 7, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 1, 8, 8, 3, 8, 8, 0, 0, 1, 7, 7)); // swap
    vecs.push_back(v(0, 0, 1, 0, 0, 2, 2, 2, 0, 0, 1, 8, 8));
    vecs.push_back(v(0, 1, 0, 5, 5, 3, 5, 5, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 1, 1, 6, 6, 0, 0, 0, 0, 0, 0, 0, 0)); // clear wins
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 12, 13, 1, 12, 13, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 12, 13));

    // Reset state.
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    last_out.x = '0; last_out.y = '0;
    #12;
    check("reset.count", 32'(count), 0);
    check("reset.flags", {empty, full, out_valid, overflow, underflow}, 5'b10000);
    check("reset.xy", {x_out, y_out}, 8'h00);
    check("reset.top", {top_x, top_y}, 8'h00);
    #10 rst = 1'b0;

    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

    // Asynchronous reset mid-operation.
    apply(v(0, 1, 0, 1, 2, 1, 1, 2, 0, 0, 0, 0, 0), "r0");
    apply(v(0, 1, 0, 3, 4, 2, 3, 4, 0, 0, 0, 0, 0), "r1");
    apply(v(0, 0, 1, 0, 0, 1, 1, 2, 0, 0, 1, 3, 4), "r2");
    drive(0, 1, 0, 5, 5);
    #3 rst = 1'b1;
    #1;
    check("arst.count", 32'(count), 0);
    check("arst.xy", {x_out, y_out}, 8'h00);
    check("arst.flags", {empty, full, out_valid, overflow, underflow}, 5'b10000);
    check("arst.top", {top_x, top_y}, 8'h00);
    last_out.x = '0; last_out.y = '0;
    sb.delete();
    @(posedge clk); #1;
    check("arst.push_ignored", 32'(count), 0);
    #2 rst = 1'b0;
    apply(v(0, 1, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0), "post_rst_push");
    apply(v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1), "post_rst_pop");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/coord_stack.md
COORD_STACK -- requirements
Module: coord_stack

Interface
REQ-001 SHALL have parameter XW, default 4, x coordinate width in bits (>=1).
REQ-002 SHALL have parameter YW, default 4, y coordinate width in bits (>=1).
REQ-003 SHALL have parameter DEPTH, default 16, entry capacity (>=2, any integer); CW = clog2(DEPTH+1).
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port clear  input  1  synchronous flush of all entries.
REQ-007 SHALL have port push  input  1  write {x_in,y_in} on top.
REQ-008 SHALL have port pop  input  1  remove top entry to x_out/y_out.
REQ-009 SHALL have port x_in  input  XW  x coordinate to push.
REQ-010 SHALL have port y_in  input  YW  y coordinate to push.
REQ-011 SHALL have port x_out  output  XW  registered popped x.
REQ-012 SHALL have port y_out  output  YW  registered popped y.
REQ-013 SHALL have port out_valid  output  1  one-cycle pulse: x_out/y_out updated by a pop.
REQ-014 SHALL have port top_x  output  XW  combinational current top x; 0 when empty.
REQ-015 SHALL have port top_y  output  YW  combinational current top y; 0 when empty.
REQ-016 SHALL have port count  output  CW  current entry count, 0..DEPTH.
REQ-017 SHALL have port empty  output  1  count==0, combinational from count.
REQ-018 SHALL have port full  output  1  count==DEPTH, combinational from count.
REQ-019 SHALL have port overflow  output  1  one-cycle pulse: push rejected.
REQ-020 SHALL have port underflow  output  1  one-cycle pulse: pop rejected.

Function
REQ-021 SHALL store entries in DEPTH x (XW+YW) memory; count is write index of next free slot; top = slot count-1.
REQ-022 SHALL apply command priority per cycle: clear > (push and pop) > push > pop > idle.
REQ-023 SHALL on clear: count<=0, out_valid/overflow/underflow<=0, x_out/y_out hold; push/pop ignored.
REQ-024 SHALL on push only, not full: write slot count, count<=count+1, no flag.
REQ-025 SHALL on push only, full: no write, count unchanged, overflow<=1 for one cycle.
REQ-026 SHALL on pop only, not empty: x_out/y_out<=top entry, out_valid<=1, count<=count-1 (1-cycle latency).
REQ-027 SHALL on pop only, empty: count stays 0, underflow<=1, out_valid<=0, x_out/y_out hold.
REQ-028 SHALL on push and pop, not empty (incl. full): output old top (out_valid<=1), overwrite top with input, count unchanged, no flags.
REQ-029 SHALL on push and pop, empty: forward x_in/y_in to x_out/y_out, out_valid<=1, count stays 0, no flags.
REQ-030 SHALL deassert out_valid, overflow, underflow in every cycle not covered by REQ-026/028/029, 025, 027 respectively.
REQ-031 SHALL never wrap count below 0 or above DEPTH; memory index SHALL stay within 0..DEPTH-1.
REQ-032 SHALL leave memory contents unchanged except by REQ-024/028 writes.

Reset
REQ-033 SHALL on rst high, immediately and regardless of clk: count=0, x_out=0, y_out=0, out_valid=0, overflow=0, underflow=0; empty=1, full=0.
REQ-034 SHALL not clear memory contents on reset; unreadable because count=0.
REQ-035 SHALL, with rst asserted mid-operation, discard that cycle's push/pop/clear; first command accepted at first rising edge after rst falls.

Verification (XW=YW=4, DEPTH=4)
REQ-036 SHALL check: push (1,2),(3,4),(5,6) then 3 pops -> x_out/y_out = (5,6),(3,4),(1,2) on successive cycles, out_valid=1 each, empty=1 after.
REQ-037 SHALL check: push 4 entries, push (9,9) -> full=1, overflow pulse 1 cycle, count=4, top=(4th entry) unchanged.
REQ-038 SHALL check: pop while empty -> underflow=1 one cycle, out_valid=0, count=0, x_out/y_out hold previous values.
REQ-039 SHALL check: with (7,7) on top, push (8,8)+pop -> x_out=(7,7), out_valid=1, top=(8,8), count unchanged; when empty, push (2,3)+pop -> x_out/y_out=(2,3), count=0.
REQ-040 SHALL check: push 3 entries, clear with push=1 -> count=0, empty=1, no write, no flags.
REQ-041 SHALL check: push 2 entries, assert rst between clock edges -> count=0, outputs 0 immediately; push (1,1) after release -> count=1, top=(1,1).
